// File: rtl/mem_lsu.sv
// Load/store unit: one RV32I load/store per request, issued as a word-aligned byte-strobed
// bus access; stalls the pipeline until the access completes, errors out, or is flushed.
module mem_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic        LS_VALID,
  input  logic        LS_WE,
  input  logic [2:0]  LS_FUNCT3,
  input  logic [31:0] LS_ADDR,
  input  logic [31:0] LS_WDATA,
  output logic        LS_STALL,
  output logic        LS_DONE,
  output logic [31:0] LS_RDATA,
  output logic        LS_ERR,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_STRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_READY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RWAIT, S_DONE, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            err_q, err_d;
  logic [31:0]     rdata_q;
  logic [CW-1:0]   cnt_q;
  logic            latch_req;
  logic            load_rdata;
  logic            misaligned_in;
  logic            waiting;
  logic            to_hit;
  logic [1:0]      a;
  logic [3:0]      strb;
  logic [31:0]     lane_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;

  assign a = addr_q[1:0];

  // funct3[1:0]: 00 byte, 01 half, anything else treated as a word access
  assign misaligned_in = (LS_FUNCT3[1:0] == 2'b01 && LS_ADDR[0]) ||
                         (LS_FUNCT3[1] && LS_ADDR[1:0] != 2'b00);

  assign waiting = (state_q == S_REQ) || (state_q == S_RWAIT) || (state_q == S_DRAIN);
  assign to_hit  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    strb       = 4'b1111;
    lane_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        strb       = 4'b0001 << a;
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb       = 4'b0011 << a;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = MEM_RDATA[{a, 3'b000} +: 8];
  assign ld_half = MEM_RDATA[{a[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = MEM_RDATA;
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = MEM_RDATA;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    latch_req  = 1'b0;
    load_rdata = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!FLUSH && LS_VALID) begin
          latch_req = 1'b1;
          err_d     = misaligned_in;
          state_d   = misaligned_in ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // a load accepted in the flush cycle still owes us a response, so drain it
        if (FLUSH)
          state_d = (MEM_READY && !we_q) ? S_DRAIN : S_IDLE;
        else if (MEM_READY)
          state_d = we_q ? S_DONE : S_RWAIT;
        else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RWAIT: begin
        // response arriving together with the flush is already consumed
        if (FLUSH)
          state_d = MEM_RVALID ? S_IDLE : S_DRAIN;
        else if (MEM_RVALID) begin
          load_rdata = 1'b1;
          state_d    = S_DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (MEM_RVALID || to_hit)
          state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (latch_req) begin
        we_q    <= LS_WE;
        f3_q    <= LS_FUNCT3;
        addr_q  <= LS_ADDR;
        wdata_q <= LS_WDATA;
      end
      if (load_rdata)
        rdata_q <= ld_data;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (waiting)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign LS_STALL  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign LS_DONE   = (state_q == S_DONE);
  assign LS_ERR    = LS_DONE && err_q;
  assign LS_RDATA  = (LS_DONE && (we_q || err_q)) ? 32'h0 : rdata_q;
  assign MEM_REQ   = (state_q == S_REQ);
  assign MEM_WE    = MEM_REQ && we_q;
  assign MEM_ADDR  = MEM_REQ ? {addr_q[31:2], 2'b00} : 32'h0;
  assign MEM_STRB  = MEM_REQ ? strb : 4'b0000;
  assign MEM_WDATA = MEM_REQ ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed accesses, a per-cycle monitor against a request-level model,
// and literal expectations for bus lanes, stall length, completion timing and load data.
module tb_mem_lsu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FLUSH = 1'b0;
  logic        LS_VALID = 1'b0;
  logic        LS_WE = 1'b0;
  logic [2:0]  LS_FUNCT3 = 3'b000;
  logic [31:0] LS_ADDR = 32'h0;
  logic [31:0] LS_WDATA = 32'h0;
  logic        LS_STALL, LS_DONE, LS_ERR;
  logic [31:0] LS_RDATA;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_STRB;
  logic        MEM_READY = 1'b0;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = 32'h0;

  mem_lsu #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .LS_VALID(LS_VALID), .LS_WE(LS_WE), .LS_FUNCT3(LS_FUNCT3),
    .LS_ADDR(LS_ADDR), .LS_WDATA(LS_WDATA),
    .LS_STALL(LS_STALL), .LS_DONE(LS_DONE), .LS_RDATA(LS_RDATA), .LS_ERR(LS_ERR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_STRB(MEM_STRB),
    .MEM_WDATA(MEM_WDATA), .MEM_READY(MEM_READY), .MEM_RVALID(MEM_RVALID),
    .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // request-level model of the access in flight
  logic        m_we;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata;
  logic        m_bus, m_done_ok, m_exp_err;
  logic [31:0] m_exp_rdata;

  // observations gathered by the monitor
  int          req_seen = 0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_strb = 4'h0;
  logic        last_done_err = 1'b0;

  // per-access bookkeeping in the stimulus
  int stall_cnt, done_cnt, done_k, req0;
  logic stall_after_rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
    int n = nbytes(f3);
    return 4'(((1 << n) - 1) << addr[1:0]);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rsp);
    int n = nbytes(f3);
    logic [31:0] v = rsp >> (8 * addr[1:0]);
    logic [31:0] mask;
    if (n == 4) return rsp;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int n = nbytes(f3);
    return (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
  endfunction

  always @(negedge CLK) begin
    if (MEM_REQ) begin
      req_seen++;
      last_addr  = MEM_ADDR;
      last_strb  = MEM_STRB;
      last_wdata = MEM_WDATA;
      check("mem_req_allowed", {31'b0, m_bus}, 32'd1);
      check("mem_addr", MEM_ADDR, {m_addr[31:2], 2'b00});
      check("mem_strb", {28'b0, MEM_STRB}, {28'b0, exp_strb(m_f3, m_addr)});
      check("mem_we", {31'b0, MEM_WE}, {31'b0, m_we});
      if (m_we) check("mem_wdata", MEM_WDATA, exp_wdata(m_f3, m_wdata));
    end
    if (LS_DONE) begin
      last_done_err = LS_ERR;
      check("done_allowed", {31'b0, m_done_ok}, 32'd1);
      check("ls_err", {31'b0, LS_ERR}, {31'b0, m_exp_err});
      check("ls_rdata", LS_RDATA, m_exp_rdata);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rsp,
                       input logic done_ok, input logic tmo);
    logic mis = misaligned(f3, addr);
    m_we = we; m_f3 = f3; m_addr = addr; m_wdata = wd;
    m_bus       = !mis;
    m_done_ok   = done_ok;
    m_exp_err   = mis || tmo;
    m_exp_rdata = (we || mis || tmo) ? 32'h0 : exp_load(f3, addr, rsp);
    req0 = req_seen;
    LS_VALID = 1'b1; LS_WE = we; LS_FUNCT3 = f3; LS_ADDR = addr; LS_WDATA = wd;
    MEM_READY = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = rsp;
    tick();
    LS_VALID = 1'b0;
    stall_cnt = int'(LS_STALL);
    done_cnt  = int'(LS_DONE);
    done_k    = LS_DONE ? 0 : -1;
  endtask

  task automatic run(input int n, input int rdy_from, input int rv_at, input int fl_at);
    for (int k = 1; k <= n; k++) begin
      MEM_READY  = (k >= rdy_from);
      MEM_RVALID = (k == rv_at);
      FLUSH      = (k == fl_at);
      tick();
      stall_cnt += int'(LS_STALL);
      if (LS_DONE) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == rv_at) stall_after_rv = LS_STALL;
    end
    MEM_READY = 1'b0; MEM_RVALID = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {23'b0, LS_STALL, LS_DONE, LS_ERR, MEM_REQ, MEM_WE, MEM_STRB}, 32'h0);
    check({tag, "_ls_rdata"}, LS_RDATA, 32'h0);
    check({tag, "_mem_addr"}, MEM_ADDR, 32'h0);
    check({tag, "_mem_wdata"}, MEM_WDATA, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_we = 1'b0; m_f3 = 3'b0; m_addr = 32'h0; m_wdata = 32'h0;
    m_bus = 1'b0; m_done_ok = 1'b0; m_exp_err = 1'b0; m_exp_rdata = 32'h0;
    stall_after_rv = 1'b1;
    RST_N = 1'b0;
    #2;
    check_all_zero("reset");
    #10 RST_N = 1'b1;
    tick();

    // LB at 0x1003, signed byte from lane 3
    issue(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 1'b1, 1'b0);
    run(6, 1, 3, 99);
    check("lb_done_k", done_k, 32'd3);
    check("lb_done_cnt", done_cnt, 32'd1);
    check("lb_stall_cycles", stall_cnt, 32'd3);
    check("lb_req_cycles", req_seen - req0, 32'd1);
    check("lb_addr", last_addr, 32'h0000_1000);
    check("lb_strb", {28'b0, last_strb}, 32'h8);
    check("lb_rdata", LS_RDATA, 32'hFFFF_FF80);

    // SH at 0x2002 with the bus stalling four cycles
    issue(1'b1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 1'b1, 1'b0);
    run(7, 5, 99, 99);
    check("sh_done_k", done_k, 32'd5);
    check("sh_done_cnt", done_cnt, 32'd1);
    check("sh_req_cycles", req_seen - req0, 32'd5);
    check("sh_addr", last_addr, 32'h0000_2000);
    check("sh_strb", {28'b0, last_strb}, 32'hC);
    check("sh_wdata", last_wdata, 32'hABCD_ABCD);

    // misaligned LW never reaches the bus
    issue(1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 1'b1, 1'b0);
    run(3, 1, 99, 99);
    check("lw_mis_done_k", done_k, 32'd0);
    check("lw_mis_req_cycles", req_seen - req0, 32'd0);
    check("lw_mis_stall", stall_cnt, 32'd0);
    check("lw_mis_err", {31'b0, last_done_err}, 32'd1);

    // LHU with a bus that never answers
    issue(1'b0, 3'b101, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    run(10, 99, 99, 99);
    check("tmo_req_cycles", req_seen - req0, 32'd8);
    check("tmo_done_k", done_k, 32'd8);
    check("tmo_done_cnt", done_cnt, 32'd1);
    check("tmo_err", {31'b0, last_done_err}, 32'd1);

    // next access after the timeout is handled normally
    issue(1'b0, 3'b010, 32'h4, 32'h0, 32'h1234_5678, 1'b1, 1'b0);
    run(4, 1, 2, 99);
    check("lw_after_tmo_done_k", done_k, 32'd2);
    check("lw_after_tmo_rdata", LS_RDATA, 32'h1234_5678);

    // LW flushed while waiting for read data
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run(7, 1, 5, 2);
    check("flush_done_cnt", done_cnt, 32'd0);
    check("flush_stall_cycles", stall_cnt, 32'd5);
    check("flush_stall_after_rvalid", {31'b0, stall_after_rv}, 32'd0);
    check("flush_rdata_kept", LS_RDATA, 32'h1234_5678);

    // asynchronous reset in the middle of a read
    issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 1'b0);
    run(2, 1, 99, 99);
    check("pre_reset_stall", {31'b0, LS_STALL}, 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check_all_zero("midreset");
    #10 RST_N = 1'b1;
    tick();

    // SB at 0x5 after reset
    issue(1'b1, 3'b000, 32'h5, 32'h0000_00A5, 32'h0, 1'b1, 1'b0);
    run(3, 1, 99, 99);
    check("sb_done_k", done_k, 32'd1);
    check("sb_addr", last_addr, 32'h0000_0004);
    check("sb_strb", {28'b0, last_strb}, 32'h2);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit for the RV32I core. It sits between the ALU stage and the data memory, as the bus-side counterpart of the memory-read pipeline register. It takes one load or store per request from the ALU stage and issues a word-aligned, byte-strobed transaction on the data-memory bus. It holds the pipeline stalled until the access completes, then returns extended load data to the memory-read stage.

Parameters:
TIMEOUT, 255, max cycles spent in any single waiting state before the access is aborted with an error; 0 disables the timeout.

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
FLUSH  in  1  pipeline flush; discards the current access, see abort rules
LS_VALID  in  1  access request from the ALU stage, sampled only in IDLE
LS_WE  in  1  1 = store, 0 = load
LS_FUNCT3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
LS_ADDR  in  32  byte address
LS_WDATA  in  32  store data, right-aligned
LS_STALL  out  1  high while an access is in flight; drives pipeline STALL
LS_DONE  out  1  one-cycle completion pulse
LS_RDATA  out  32  extended load data, valid with LS_DONE on loads
LS_ERR  out  1  one-cycle pulse (with LS_DONE): misaligned access or timeout
MEM_REQ  out  1  bus request
MEM_WE  out  1  bus write enable
MEM_ADDR  out  32  word address, bits [1:0] = 0
MEM_STRB  out  4  byte lanes
MEM_WDATA  out  32  lane-shifted store data
MEM_READY  in  1  request accepted when MEM_REQ && MEM_READY
MEM_RVALID  in  1  read data valid, one cycle per accepted read
MEM_RDATA  in  32  read data word

Behaviour:
- Reset (async, RST_N=0): state IDLE. All outputs 0; internal counters and latched request fields are 0.
- States: IDLE, REQ, RWAIT, DONE, DRAIN.
- IDLE + LS_VALID + !FLUSH: latch WE, funct3, addr, wdata. Check alignment:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - Misaligned: go to DONE with error set; no bus activity.
  - Aligned: go to REQ.
- LS_STALL = (state != IDLE) && (state != DONE). It is registered from state, so it rises the cycle after LS_VALID is sampled. The ALU stage holds LS_* stable until LS_DONE.
- Lane mapping from addr[1:0]:
  - B: STRB = 0001 << a; WDATA = {4{wdata[7:0]}}.
  - H: STRB = 0011 << a; WDATA = {2{wdata[15:0]}}.
  - W: STRB = 1111; WDATA = wdata.
  - Loads drive the same STRB with MEM_WE=0.
- REQ:
  - MEM_REQ=1 and all MEM_* held stable until MEM_READY.
  - On handshake, a store goes to DONE and a load goes to RWAIT.
  - MEM_RVALID arriving in the same cycle as the read handshake is not allowed; a response earliest one cycle later is required.
- RWAIT:
  - On MEM_RVALID, select the byte/half at addr[1:0].
  - Sign-extend for B/H, zero-extend for BU/HU, pass W through.
  - Register the result into LS_RDATA and go to DONE.
- DONE: LS_DONE=1 and LS_ERR=err for exactly one cycle, then IDLE. LS_RDATA holds its value until the next load completes.
- LS_RDATA is 0 on stores and errors.
- Timeout:
  - A cycle counter clears on every state entry and increments each cycle in REQ or RWAIT.
  - When it reaches TIMEOUT-1 without the awaited handshake: MEM_REQ drops, go to DONE with err=1.
  - After a read timeout, a late MEM_RVALID is ignored.
- FLUSH (has priority over all other transitions):
  - IDLE or DONE: go to IDLE with no pulse.
  - REQ before the handshake: MEM_REQ drops the next cycle, go to IDLE.
  - REQ in the handshake cycle, load: go to DRAIN.
  - REQ in the handshake cycle, store: the store is committed, go to IDLE.
  - RWAIT: go to DRAIN.
  - DRAIN: stays stalled until MEM_RVALID (or timeout), then goes to IDLE with the data discarded and no LS_DONE.
- LS_VALID asserted outside IDLE is ignored.

Test Plan:
- LB at addr 0x1003, MEM_READY immediate, MEM_RVALID 2 cycles later with RDATA 0x80FF_1234 -> MEM_ADDR 0x1000, STRB 1000; LS_RDATA 0xFFFF_FF80; LS_STALL high 3 cycles, one LS_DONE pulse.
- SH at 0x2002, wdata 0x0000_ABCD, MEM_READY held low 4 cycles -> MEM_REQ/ADDR 0x2000/STRB 1100/WDATA 0xABCD_ABCD stable all 5 cycles; LS_DONE the cycle after the handshake.
- LW at 0x3001 -> no MEM_REQ ever; LS_DONE and LS_ERR pulse together; LS_RDATA 0.
- LHU at 0x0, MEM_READY never, TIMEOUT=8 -> MEM_REQ high 8 cycles then drops; LS_ERR pulse; next LS_VALID accepted normally.
- LW at 0x10 accepted, FLUSH in RWAIT, MEM_RVALID 3 cycles later with 0xDEADBEEF -> no LS_DONE; LS_RDATA unchanged; LS_STALL low the cycle after RVALID.
- RST_N pulsed low mid-RWAIT (asynchronous to CLK) -> all outputs 0 immediately; IDLE on release; a following SB at 0x5 completes with STRB 0010.
